// File: rtl/test_pkg.sv
// Shared definitions for the test-pattern checker and its matching generator.
// Holds FSM encodings, error-cause codes and the scrambler LFSR step.
// Pure declarations; no logic, no latency, no flow control.
package test_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_RX   = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   localparam logic [2:0] EC_NONE  = 3'd0;
   localparam logic [2:0] EC_CMP   = 3'd1;
   localparam logic [2:0] EC_CRC   = 3'd2;
   localparam logic [2:0] EC_FRERR = 3'd3;
   localparam logic [2:0] EC_SOF   = 3'd4;
   localparam logic [2:0] EC_LEN   = 3'd5;

   // Scrambler words are 32 bits drawn from a serial x^16+x^15+x^13+x^4+1 sequence
   localparam int SCR_WORD_W = 32;

   // One serial step: window holds the 16 oldest unconsumed sequence bits, bit 0 first
   function automatic logic [15:0] scr_step(input logic [15:0] s);
      return {s[15] ^ s[13] ^ s[4] ^ s[0], s[15:1]};
   endfunction

endpackage

// File: rtl/sata_scrambler.sv
// Pattern scrambler: presents the current 32-bit sequence word, low G_DATA_W bits.
// Zero latency on the output; advances one word per enabled cycle.
// No backpressure: p_in_SOF reseeds and wins over p_in_en.
module sata_scrambler
   import test_pkg::*;
#(
   parameter logic [15:0] G_INIT_VAL = 16'h55AA,
   parameter int          G_DATA_W   = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                p_in_SOF,
   input  logic                p_in_en,
   output logic [G_DATA_W-1:0] p_out_data
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_nxt;

   // Unroll one word of serial steps: emit the low bits, then skip to the next word
   always_comb begin
      logic [15:0] st;
      st         = lfsr_q;
      p_out_data = '0;
      for (int j = 0; j < G_DATA_W; j++) begin
         p_out_data[j] = st[0];
         st            = scr_step(st);
      end
      for (int j = G_DATA_W; j < SCR_WORD_W; j++) begin
         st = scr_step(st);
      end
      lfsr_nxt = st;
   end

   // Sequence state: reseed on reset or frame start, otherwise advance when enabled
   always_ff @(posedge clk) begin
      if (!rst) begin
         lfsr_q <= G_INIT_VAL;
      end else if (p_in_SOF) begin
         lfsr_q <= G_INIT_VAL;
      end else if (p_in_en) begin
         lfsr_q <= lfsr_nxt;
      end
   end

endmodule

// File: rtl/test_rx_chk.sv
// Receive-side test-pattern checker: compares MAC beats against the scrambler pattern.
// Zero-latency compare; status/counters update on the clock edge that accepts the beat.
// Never stalls the MAC: every valid beat is accepted, errored frames are dropped to eof.
module test_rx_chk
   import test_pkg::*;
#(
   parameter int          DATA_W    = 8,
   parameter logic [15:0] SEED      = 16'h55AA,
   parameter int          MAX_BEATS = 1024,
   parameter int          CNT_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] mac_rx_data,
   input  logic              mac_rx_valid,
   input  logic              mac_rx_sof,
   input  logic              mac_rx_eof,
   input  logic              mac_rx_fr_good,
   input  logic              mac_rx_fr_err,
   input  logic              start,
   input  logic              mode_cont,
   input  logic              clr_cnt,
   output logic              err,
   output logic [2:0]        err_code,
   output logic              busy,
   output logic [DATA_W-1:0] test_data,
   output logic [CNT_W-1:0]  good_cnt,
   output logic [CNT_W-1:0]  bad_cnt,
   output logic [CNT_W-1:0]  beat_cnt
);

   localparam int               IDX_W   = $clog2(MAX_BEATS + 1);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(MAX_BEATS);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state;
   state_t           state_nxt;
   logic [IDX_W-1:0] idx_q;
   logic             drop_q;
   logic [2:0]       beat_code;
   logic             rx_beat;
   logic             chk_beat;
   logic             frame_end;
   logic             beat_bad;
   logic             good_end;
   logic             reseed;
   logic             scr_en;

   assign rx_beat   = (state == ST_RX) && mac_rx_valid;
   assign chk_beat  = rx_beat && !drop_q;
   assign frame_end = rx_beat && mac_rx_eof;
   assign beat_bad  = chk_beat && (beat_code != EC_NONE);
   assign good_end  = chk_beat && mac_rx_eof && !beat_bad;

   sata_scrambler #(
      .G_INIT_VAL (SEED),
      .G_DATA_W   (DATA_W)
   ) u_scr (
      .clk        (clk),
      .rst        (rst),
      .p_in_SOF   (reseed),
      .p_in_en    (scr_en),
      .p_out_data (test_data)
   );

   // Highest-priority cause for the current beat: FRERR > CRC > CMP > SOF > LEN
   always_comb begin
      beat_code = EC_NONE;
      if (mac_rx_fr_err) begin
         beat_code = EC_FRERR;
      end else if (mac_rx_eof && !mac_rx_fr_good) begin
         beat_code = EC_CRC;
      end else if (mac_rx_data != test_data) begin
         beat_code = EC_CMP;
      end else if (mac_rx_sof != (idx_q == '0)) begin
         beat_code = EC_SOF;
      end else if (idx_q >= IDX_MAX) begin
         beat_code = EC_LEN;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state; an RX with no frame in progress may drop back to IDLE when start falls
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_ARM;
         ST_ARM:  state_nxt = start ? ST_RX : ST_IDLE;
         ST_RX: begin
            if (beat_bad && !mode_cont) begin
               state_nxt = ST_ERR;
            end else if (frame_end) begin
               state_nxt = start ? ST_ARM : ST_IDLE;
            end else if (!start && !rx_beat && (idx_q == '0) && !drop_q) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_ERR:  if (!start) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // FSM outputs: busy flag, scrambler advance and reseed strobes
   always_comb begin
      busy   = (state != ST_IDLE);
      scr_en = rx_beat;
      reseed = ((state == ST_IDLE) && start) || frame_end;
   end

   // Beat index within the frame (saturating past MAX_BEATS) and the drop-to-eof flag
   always_ff @(posedge clk) begin
      if (!rst || (state != ST_RX)) begin
         idx_q  <= '0;
         drop_q <= 1'b0;
      end else if (rx_beat) begin
         if (frame_end) begin
            idx_q  <= '0;
            drop_q <= 1'b0;
         end else begin
            if (idx_q != IDX_MAX) idx_q <= idx_q + IDX_W'(1);
            if (beat_bad && mode_cont) drop_q <= 1'b1;
         end
      end
   end

   // Sticky error flag and first cause, cleared only when a new run is armed
   always_ff @(posedge clk) begin
      if (!rst) begin
         err      <= 1'b0;
         err_code <= EC_NONE;
      end else if ((state == ST_IDLE) && start) begin
         err      <= 1'b0;
         err_code <= EC_NONE;
      end else if (beat_bad) begin
         err <= 1'b1;
         if (!err) err_code <= beat_code;
      end
   end

   // Saturating statistics; clear wins over any same-cycle increment
   always_ff @(posedge clk) begin
      if (!rst || clr_cnt) begin
         good_cnt <= '0;
         bad_cnt  <= '0;
         beat_cnt <= '0;
      end else begin
         if (good_end && (good_cnt != CNT_MAX)) good_cnt <= good_cnt + CNT_W'(1);
         if (beat_bad && (bad_cnt != CNT_MAX))  bad_cnt  <= bad_cnt + CNT_W'(1);
         if (rx_beat && (beat_cnt != CNT_MAX))  beat_cnt <= beat_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_test_rx_chk.sv
// Self-checking bench for test_rx_chk: directed frame table, hand sequences, random frames.
// Pattern words come from an independently generated serial bit sequence.
// Stimulus is never stalled by the DUT; idle (valid=0) cycles are sprinkled inside frames.
module tb_test_rx_chk;
   import test_pkg::*;

   typedef struct {
      bit     restart;
      bit     mode;
      int     len;
      int     bad;
      int     frerr;
      int     sofb;
      bit     crc_bad;
      int     exp_good;
      int     exp_bad;
      int     exp_beats;
      bit     exp_err;
      int     exp_code;
      state_t exp_st;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DUT A: default parameters
   logic        a_rst, a_valid, a_sof, a_eof, a_good, a_frerr, a_start, a_mode, a_clr;
   logic [7:0]  a_data;
   logic        a_err, a_busy;
   logic [2:0]  a_code;
   logic [7:0]  a_tdata;
   logic [31:0] a_gc, a_bc, a_btc;

   // DUT B: wide datapath, short frames, narrow counters
   logic        b_rst, b_valid, b_sof, b_eof, b_good, b_frerr, b_start, b_mode, b_clr;
   logic [31:0] b_data;
   logic        b_err, b_busy;
   logic [2:0]  b_code;
   logic [31:0] b_tdata;
   logic [3:0]  b_gc, b_bc, b_btc;

   int n_chk  = 0;
   int n_fail = 0;
   bit pbits [0:2559];

   test_rx_chk dut_a (
      .clk(clk), .rst(a_rst), .mac_rx_data(a_data), .mac_rx_valid(a_valid),
      .mac_rx_sof(a_sof), .mac_rx_eof(a_eof), .mac_rx_fr_good(a_good), .mac_rx_fr_err(a_frerr),
      .start(a_start), .mode_cont(a_mode), .clr_cnt(a_clr), .err(a_err), .err_code(a_code),
      .busy(a_busy), .test_data(a_tdata), .good_cnt(a_gc), .bad_cnt(a_bc), .beat_cnt(a_btc));

   test_rx_chk #(.DATA_W(32), .MAX_BEATS(16), .CNT_W(4)) dut_b (
      .clk(clk), .rst(b_rst), .mac_rx_data(b_data), .mac_rx_valid(b_valid),
      .mac_rx_sof(b_sof), .mac_rx_eof(b_eof), .mac_rx_fr_good(b_good), .mac_rx_fr_err(b_frerr),
      .start(b_start), .mode_cont(b_mode), .clr_cnt(b_clr), .err(b_err), .err_code(b_code),
      .busy(b_busy), .test_data(b_tdata), .good_cnt(b_gc), .bad_cnt(b_bc), .beat_cnt(b_btc));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Word k of the pattern: bits 32k..32k+31 of the serial sequence, LSB first
   function automatic logic [31:0] pat(input int k);
      logic [31:0] w;
      for (int j = 0; j < 32; j++) w[j] = pbits[32*k + j];
      return w;
   endfunction

   task automatic a_junk();
      a_valid = 1'b0;
      a_data  = 8'($urandom);
      a_sof   = 1'($urandom);
      a_eof   = 1'($urandom);
      a_good  = 1'($urandom);
      a_frerr = 1'($urandom);
   endtask

   task automatic restart();
      a_start = 1'b0;
      tick();
      tick();
      a_start = 1'b1;
      tick();
      tick();
   endtask

   // Drive one frame with optional defects; report FSM state and test_data right after eof
   task automatic send_frame(input int len, input int bad, input int frerr, input int sofb,
                             input bit crc_bad, input int stop_beat, input bit clr_eof,
                             output logic [1:0] st, output logic [7:0] td);
      logic [31:0] w;
      for (int k = 0; k < len; k++) begin
         for (int g = 0; g < 3 && $urandom_range(0, 3) == 0; g++) begin
            a_junk();
            tick();
         end
         w       = pat(k);
         a_valid = 1'b1;
         a_data  = w[7:0] ^ ((k == bad) ? 8'h01 : 8'h00);
         a_sof   = (k == 0) ^ (k == sofb);
         a_eof   = (k == len - 1);
         a_good  = (k == len - 1) && !crc_bad;
         a_frerr = (k == frerr);
         a_clr   = clr_eof && (k == len - 1);
         if (k == stop_beat) a_start = 1'b0;
         tick();
      end
      st = dut_a.state;
      td = a_tdata;
      a_junk();
      a_clr = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t        tbl [9];
      logic [15:0] seed_v;
      logic [31:0] w0, w;
      logic [7:0]  w0b;
      logic [1:0]  st;
      logic [7:0]  td;
      int m_good, m_bad, m_beats, m_code, first, len, bad, frerr, sofb;
      bit m_err, crc;

      // Reference pattern: b[n] = b[n-1]^b[n-3]^b[n-12]^b[n-16], seeded with SEED
      seed_v = 16'h55AA;
      for (int i = 0; i < 16; i++) pbits[i] = seed_v[i];
      for (int n = 16; n < 2560; n++)
         pbits[n] = pbits[n-1] ^ pbits[n-3] ^ pbits[n-12] ^ pbits[n-16];
      w0  = pat(0);
      w0b = w0[7:0];

      tbl[0] = '{1'b0, 1'b1, 64, -1, -1, -1, 1'b0, 1, 0,  64, 1'b0, 0, ST_ARM};
      tbl[1] = '{1'b0, 1'b1, 10, -1, -1, -1, 1'b1, 1, 1,  74, 1'b1, 2, ST_ARM};
      tbl[2] = '{1'b0, 1'b1, 12, -1, -1, -1, 1'b0, 2, 1,  86, 1'b1, 2, ST_ARM};
      tbl[3] = '{1'b1, 1'b1,  8,  3,  3, -1, 1'b0, 2, 2,  94, 1'b1, 3, ST_ARM};
      tbl[4] = '{1'b0, 1'b1,  5, -1, -1,  0, 1'b0, 2, 3,  99, 1'b1, 3, ST_ARM};
      tbl[5] = '{1'b1, 1'b1,  6,  2, -1,  2, 1'b0, 2, 4, 105, 1'b1, 1, ST_ARM};
      tbl[6] = '{1'b1, 1'b1,  4, -1, -1,  1, 1'b0, 2, 5, 109, 1'b1, 4, ST_ARM};
      tbl[7] = '{1'b0, 1'b1,  3, -1, -1, -1, 1'b0, 3, 5, 112, 1'b1, 4, ST_ARM};
      tbl[8] = '{1'b1, 1'b0, 20, 10, -1, -1, 1'b0, 3, 6, 123, 1'b1, 1, ST_ERR};

      a_rst = 1'b0; a_data = '0; a_valid = 1'b0; a_sof = 1'b0; a_eof = 1'b0; a_good = 1'b0;
      a_frerr = 1'b0; a_start = 1'b0; a_mode = 1'b1; a_clr = 1'b0;
      b_rst = 1'b0; b_data = '0; b_valid = 1'b0; b_sof = 1'b0; b_eof = 1'b0; b_good = 1'b0;
      b_frerr = 1'b0; b_start = 1'b0; b_mode = 1'b0; b_clr = 1'b0;
      tick();
      tick();

      // Reset values
      check("rst err", a_err, 0);
      check("rst err_code", a_code, 0);
      check("rst busy", a_busy, 0);
      check("rst good_cnt", a_gc, 0);
      check("rst bad_cnt", a_bc, 0);
      check("rst beat_cnt", a_btc, 0);
      check("rst test_data", a_tdata, w0b);
      check("rst b test_data", b_tdata, w0);
      a_rst = 1'b1;
      b_rst = 1'b1;

      // Wide DUT: over-long frame without eof, counters saturating at 4 bits
      b_start = 1'b1;
      tick();
      tick();
      for (int k = 0; k < 20; k++) begin
         w       = pat(k);
         b_valid = 1'b1;
         b_data  = w;
         b_sof   = (k == 0);
         tick();
         if (k == 13) check("b beat_cnt 14", b_btc, 14);
         if (k == 15) check("b no err at 16 beats", b_err, 0);
         if (k == 16) begin
            check("b len err", b_err, 1);
            check("b len err_code", b_code, 5);
            check("b bad_cnt", b_bc, 1);
            check("b beat_cnt sat", b_btc, 15);
            check("b good_cnt", b_gc, 0);
            check("b state err", dut_b.state, ST_ERR);
            check("b busy", b_busy, 1);
         end
      end
      b_valid = 1'b0;

      // Directed frame table
      a_start = 1'b1;
      tick();
      tick();
      for (int i = 0; i < 9; i++) begin
         a_mode = tbl[i].mode;
         if (tbl[i].restart) restart();
         send_frame(tbl[i].len, tbl[i].bad, tbl[i].frerr, tbl[i].sofb, tbl[i].crc_bad,
                    -1, 1'b0, st, td);
         check($sformatf("v%0d good_cnt", i), a_gc, tbl[i].exp_good);
         check($sformatf("v%0d bad_cnt", i), a_bc, tbl[i].exp_bad);
         check($sformatf("v%0d beat_cnt", i), a_btc, tbl[i].exp_beats);
         check($sformatf("v%0d err", i), a_err, tbl[i].exp_err);
         check($sformatf("v%0d err_code", i), a_code, tbl[i].exp_code);
         check($sformatf("v%0d state", i), st, tbl[i].exp_st);
         if (tbl[i].exp_st == ST_ARM) check($sformatf("v%0d arm test_data", i), td, w0b);
      end

      // ERR releases to IDLE when start falls; error status persists
      a_start = 1'b0;
      tick();
      check("err->idle busy", a_busy, 0);
      check("err->idle err", a_err, 1);
      check("err->idle err_code", a_code, 1);

      // start falling mid-frame does not abort it; FSM goes idle after eof
      a_mode  = 1'b1;
      a_start = 1'b1;
      tick();
      tick();
      check("rearm clears err", a_err, 0);
      send_frame(8, -1, -1, -1, 1'b0, 3, 1'b0, st, td);
      check("stop good_cnt", a_gc, 4);
      check("stop beat_cnt", a_btc, 131);
      check("stop state", st, ST_IDLE);
      check("stop busy", a_busy, 0);

      // Reset in the middle of a frame
      a_start = 1'b1;
      tick();
      tick();
      for (int k = 0; k < 6; k++) begin
         w       = pat(k);
         a_valid = 1'b1;
         a_data  = w[7:0];
         a_sof   = (k == 0);
         a_eof   = 1'b0;
         a_good  = 1'b0;
         a_frerr = 1'b0;
         if (k == 5) a_rst = 1'b0;
         tick();
      end
      a_rst = 1'b1;
      a_junk();
      check("midrst err", a_err, 0);
      check("midrst err_code", a_code, 0);
      check("midrst busy", a_busy, 0);
      check("midrst good_cnt", a_gc, 0);
      check("midrst bad_cnt", a_bc, 0);
      check("midrst beat_cnt", a_btc, 0);
      check("midrst test_data", a_tdata, w0b);
      tick();
      tick();
      send_frame(16, -1, -1, -1, 1'b0, -1, 1'b0, st, td);
      check("post-rst good_cnt", a_gc, 1);
      check("post-rst beat_cnt", a_btc, 16);
      check("post-rst err", a_err, 0);

      // Clear coincident with a good eof wins, and only lasts one cycle
      send_frame(4, -1, -1, -1, 1'b0, -1, 1'b1, st, td);
      check("clr good_cnt", a_gc, 0);
      check("clr beat_cnt", a_btc, 0);
      send_frame(2, -1, -1, -1, 1'b0, -1, 1'b0, st, td);
      check("after clr good_cnt", a_gc, 1);
      check("after clr beat_cnt", a_btc, 2);

      // Random frames in continue mode against a frame-level model
      m_good = 1; m_bad = 0; m_beats = 2; m_err = 1'b0; m_code = 0;
      for (int f = 0; f < 40; f++) begin
         len   = $urandom_range(1, 40);
         bad   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len - 1)) : -1;
         frerr = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len - 1)) : -1;
         sofb  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len - 1)) : -1;
         crc   = ($urandom_range(0, 5) == 0);
         first = 0;
         for (int k = len - 1; k >= 0; k--) begin
            int c;
            c = 0;
            if (k == frerr) c = 3;
            else if (k == len - 1 && crc) c = 2;
            else if (k == bad) c = 1;
            else if (k == sofb) c = 4;
            if (c != 0) first = c;
         end
         m_beats += len;
         if (first != 0) begin
            m_bad++;
            if (!m_err) begin
               m_err  = 1'b1;
               m_code = first;
            end
         end else begin
            m_good++;
         end
         send_frame(len, bad, frerr, sofb, crc, -1, 1'b0, st, td);
         check($sformatf("r%0d good_cnt", f), a_gc, m_good);
         check($sformatf("r%0d bad_cnt", f), a_bc, m_bad);
         check($sformatf("r%0d beat_cnt", f), a_btc, m_beats);
         check($sformatf("r%0d err", f), a_err, m_err);
         check($sformatf("r%0d err_code", f), a_code, m_code);
         check($sformatf("r%0d state", f), st, ST_ARM);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/test_rx_chk.md
TEST_RX_CHK -- requirements
Module: test_rx_chk

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning datapath width in bits; legal values 8, 16, 32.
REQ-002 SHALL have parameter SEED, default 16'h55AA, meaning scrambler init value applied at every frame start.
REQ-003 SHALL have parameter MAX_BEATS, default 1024, meaning the largest legal frame length in beats.
REQ-004 SHALL have parameter CNT_W, default 32, meaning the width of the statistics counters.
REQ-005 SHALL have ports, in order: clk in 1 (sole clock); rst in 1 (reset, synchronous, active-low).
REQ-006 SHALL have ports mac_rx_data in DATA_W (beat data); mac_rx_valid in 1 (beat valid); mac_rx_sof in 1 (first beat); mac_rx_eof in 1 (last beat).
REQ-007 SHALL have ports mac_rx_fr_good in 1 (CRC ok, qualified by eof); mac_rx_fr_err in 1 (MAC frame error).
REQ-008 SHALL have ports start in 1 (arm/run); mode_cont in 1 (1 = log errors and continue, 0 = stop on first error); clr_cnt in 1 (clear counters).
REQ-009 SHALL have outputs err out 1 (sticky error flag); err_code out 3 (first error cause); busy out 1 (not IDLE); test_data out DATA_W (expected beat).
REQ-010 SHALL have outputs good_cnt out CNT_W (good frames); bad_cnt out CNT_W (bad frames); beat_cnt out CNT_W (beats checked).

Function
REQ-011 SHALL implement FSM states IDLE, ARM, RX, ERR.
REQ-012 IDLE: on start=1 SHALL go to ARM and pulse scrambler reseed for one cycle.
REQ-013 ARM: SHALL hold test_data equal to pattern word 0; on start=1 SHALL go to RX; on start=0 SHALL return to IDLE.
REQ-014 Pattern: expected beat k of a frame SHALL equal bits [DATA_W-1:0] of the k-th scrambler word after reseed; the scrambler SHALL advance only on mac_rx_valid in RX.
REQ-015 RX: for each valid beat SHALL compare mac_rx_data with test_data combinationally, giving zero-latency accept.
REQ-016 Error codes: 1 CMP (mismatch); 2 CRC (eof and !fr_good); 3 FRERR (fr_err); 4 SOF (sof absent on beat 0, or sof on beat >0); 5 LEN (beat index reaches MAX_BEATS without eof); 0 none.
REQ-017 Priority when causes coincide on one beat: FRERR > CRC > CMP > SOF > LEN.
REQ-018 A beat with eof, fr_good=1 and no other cause SHALL bump good_cnt, reseed the scrambler, and return to ARM in the next cycle.
REQ-019 A beat with any cause SHALL set err=1, latch err_code only if err was 0, and bump bad_cnt once per frame.
REQ-020 On an error with mode_cont=0, the FSM SHALL go to ERR.
REQ-021 On an error with mode_cont=1, the FSM SHALL discard beats until eof, then reseed and go to ARM.
REQ-022 ERR SHALL hold until start=0, then go to IDLE; err and err_code SHALL persist until the next IDLE->ARM transition.
REQ-023 beat_cnt SHALL bump on every valid beat in RX.
REQ-024 All counters SHALL saturate at all-ones.
REQ-025 clr_cnt=1 SHALL zero all three counters next cycle, taking precedence over a simultaneous increment.
REQ-026 start deasserting in RX SHALL NOT abort the current frame; the FSM SHALL return to IDLE after the frame's eof.
REQ-027 mac_rx_valid=0 beats SHALL change no state, counter or pattern.

Reset
REQ-028 rst=0 at a clk edge SHALL set: FSM to IDLE, err=0, err_code=0, busy=0, all counters to 0, scrambler to SEED.
REQ-029 Reset mid-frame SHALL discard the frame without incrementing any counter.
REQ-030 test_data after reset SHALL equal pattern word 0 bits [DATA_W-1:0].

Structure
REQ-031 State encodings and error-code constants SHALL reside in a shared package, test_pkg, for reuse by the matching generator.
REQ-032 The single sub-module SHALL be sata_scrambler, instanced with G_INIT_VAL=SEED, p_in_SOF=reseed and p_in_en=valid-and-RX.

Verification
REQ-033 DATA_W=8, start=1, one 64-beat correct frame with fr_good -> good_cnt=1, bad_cnt=0, beat_cnt=64, err=0, FSM in ARM.
REQ-034 Byte 10 of a frame XOR 8'h01, mode_cont=0 -> err=1, err_code=1, bad_cnt=1, FSM in ERR; start=0 -> IDLE.
REQ-035 mode_cont=1, three frames (good, CRC-bad, good) -> good_cnt=2, bad_cnt=1, err_code=2, third frame checks clean.
REQ-036 DATA_W=32, MAX_BEATS=16, 20-beat frame without eof -> err_code=5 at beat 16.
REQ-037 Same beat carries fr_err and a data mismatch -> err_code=3; clr_cnt coincident with a good eof -> good_cnt=0.
REQ-038 rst=0 pulsed at beat 5 of a frame -> all outputs at reset values; the next frame after start passes.
